// File: rtl/uart_pkg.sv
// Shared constants, state encodings and bit-timing helper for the
// UART transmitter and receiver.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clock_freq,
                                        input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter: tick fires once, a full or half bit period
// after load, and again only if reloaded.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= half ? HALF : FULL;
            run <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end else begin
            run <= 1'b0;
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes rx, validates the start bit at half a
// bit period, then samples data and stop bits at mid-bit.
module uartRX
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready
);

    localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

    rx_state_e  state;
    logic       rx_meta;
    logic       rx_sync;
    logic       rx_prev;
    logic       fall;
    logic [7:0] shreg;
    logic [2:0] idx;
    logic       tick;
    logic       load;
    logic       half;

    // Edge detect needs a high line first, which also re-arms after
    // a framing error only once the line has returned high.
    assign fall = rx_prev && !rx_sync;
    assign half = (state == RX_IDLE);
    assign load = (state == RX_IDLE  && fall)
               || (state == RX_START && tick && rx_sync == START_BIT)
               || (state == RX_DATA  && tick);

    uart_baud_counter #(.CLKS_PER_BIT(CPB)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .half (half),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            shreg      <= '0;
            idx        <= '0;
            data_out   <= '0;
            data_ready <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            data_ready <= 1'b0;
            unique case (state)
                RX_IDLE: if (fall) state <= RX_START;
                RX_START: if (tick) begin
                    idx   <= '0;
                    state <= (rx_sync == START_BIT) ? RX_DATA : RX_IDLE;
                end
                RX_DATA: if (tick) begin
                    shreg <= {rx_sync, shreg[7:1]};
                    if (idx == 3'(DATA_BITS - 1)) state <= RX_STOP;
                    else idx <= idx + 3'd1;
                end
                RX_STOP: if (tick) begin
                    state <= RX_IDLE;
                    if (rx_sync == STOP_BIT) begin
                        data_out   <= shreg;
                        data_ready <= 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer: latches a byte on transmit and shifts it out
// LSB first between a start and a stop bit.
module uartTX
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       transmit,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

    tx_state_e  state;
    logic [7:0] shreg;
    logic [2:0] idx;
    logic       tick;
    logic       load;

    // No reload when STOP ends; the next frame reloads on its own.
    assign load = (state == TX_IDLE) ? transmit
                                     : (tick && state != TX_STOP);

    uart_baud_counter #(.CLKS_PER_BIT(CPB)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .half (1'b0),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            shreg   <= '0;
            idx     <= '0;
            tx      <= STOP_BIT;
            tx_busy <= 1'b0;
        end else begin
            unique case (state)
                TX_IDLE: if (transmit) begin
                    shreg   <= data_in;
                    tx      <= START_BIT;
                    tx_busy <= 1'b1;
                    state   <= TX_START;
                end
                TX_START: if (tick) begin
                    tx    <= shreg[0];
                    shreg <= {1'b0, shreg[7:1]};
                    idx   <= '0;
                    state <= TX_DATA;
                end
                TX_DATA: if (tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
                        tx    <= STOP_BIT;
                        state <= TX_STOP;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        idx   <= idx + 3'd1;
                    end
                end
                TX_STOP: if (tick) begin
                    tx_busy <= 1'b0;
                    state   <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// UART pair wrapper: independent transmitter and receiver sharing
// one clock, reset and bit-rate setting.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       transmit,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready
);

    uartTX #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .transmit (transmit),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    uartRX #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_ready (data_ready)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx at 16 clocks per bit, with tx looped
// back to rx or rx driven directly.
module tb_uart_txrx;

    localparam int CF = 1600;
    localparam int BR = 100;
    localparam int N  = CF / BR;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       transmit;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       rx_drv;
    logic       loop;
    logic [7:0] data_out;
    logic       data_ready;

    int         checks = 0;
    int         failures = 0;
    int         rdy_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    assign rx = loop ? tx : rx_drv;

    uart_txrx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .transmit   (transmit),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .rx         (rx),
        .data_out   (data_out),
        .data_ready (data_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            rdy_cnt++;
            last_byte = data_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input int pulse_at,
                             output int len);
        @(negedge clk);
        data_in  = b;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        len = 0;
        while (tx_busy && len < 12 * N) begin
            len++;
            if (len == pulse_at) begin
                data_in  = 8'h3C;
                transmit = 1'b1;
            end else begin
                transmit = 1'b0;
            end
            @(negedge clk);
        end
        transmit = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (N) @(negedge clk);
        end
        rx_drv = stop;
        repeat (N) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        int         len;
        int         held;
        int         c0;
        logic [7:0] bytes [4];
        logic [9:0] fr;

        bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        rst      = 1'b1;
        loop     = 1'b1;
        rx_drv   = 1'b1;
        transmit = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_rdy", data_ready, 0);

        for (int k = 0; k < 4; k++) begin
            c0 = rdy_cnt;
            run_frame(bytes[k], 0, len);
            repeat (2 * N) @(negedge clk);
            chk("lb_len", len, 10 * N);
            chk("lb_rdy", rdy_cnt - c0, 1);
            chk("lb_byte", last_byte, bytes[k]);
        end

        c0 = rdy_cnt;
        fr = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        data_in  = 8'hA5;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            held = 0;
            for (int j = 0; j < N; j++) begin
                if (tx === fr[i] && tx_busy === 1'b1) held++;
                @(negedge clk);
            end
            chk($sformatf("bit%0d", i), held, N);
        end
        chk("bit_end_tx", tx, 1);
        chk("bit_end_busy", tx_busy, 0);
        repeat (2 * N) @(negedge clk);
        chk("bit_rdy", rdy_cnt - c0, 1);
        chk("bit_byte", last_byte, 8'hA5);

        c0 = rdy_cnt;
        run_frame(8'hA5, 4 * N, len);
        chk("ign_len", len, 10 * N);
        repeat (12 * N) @(negedge clk);
        chk("ign_busy", tx_busy, 0);
        chk("ign_rdy", rdy_cnt - c0, 1);
        chk("ign_byte", last_byte, 8'hA5);

        loop = 1'b0;
        c0 = rdy_cnt;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (N / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * N) @(negedge clk);
        chk("fs_rdy", rdy_cnt - c0, 0);
        chk("fs_dout", data_out, 8'hA5);

        c0 = rdy_cnt;
        send_raw(8'h77, 1'b0);
        repeat (2 * N) @(negedge clk);
        chk("fe_rdy", rdy_cnt - c0, 0);
        chk("fe_dout", data_out, 8'hA5);
        send_raw(8'h5A, 1'b1);
        repeat (2 * N) @(negedge clk);
        chk("fe_ok_rdy", rdy_cnt - c0, 1);
        chk("fe_ok_byte", last_byte, 8'h5A);

        loop = 1'b1;
        c0 = rdy_cnt;
        @(negedge clk);
        data_in  = 8'hB7;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (5 * N) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_tx", tx, 1);
        chk("mr_busy", tx_busy, 0);
        chk("mr_rdy", data_ready, 0);
        chk("mr_dout", data_out, 8'h00);
        rst = 1'b0;
        repeat (12 * N) @(negedge clk);
        chk("mr_none", rdy_cnt - c0, 0);
        run_frame(8'hC3, 0, len);
        repeat (2 * N) @(negedge clk);
        chk("mr_len", len, 10 * N);
        chk("mr_ok_rdy", rdy_cnt - c0, 1);
        chk("mr_ok_byte", last_byte, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

Byte-serial UART pair: `uartTX` converts a parallel byte into an asynchronous 8N1 serial frame, and `uartRX` recovers bytes from such a line. Both run from the single system clock and derive bit timing from `CLOCK_FREQ`/`BAUD_RATE`. They sit at the chip's serial pins, or are looped back TX→RX for self-test.

## Interface
- `CLOCK_FREQ`, default 100_000_000: system clock frequency in Hz, shared by both modules.
- `BAUD_RATE`, default 9600: line rate in bit/s, shared by both modules.
- Derived constant `CLKS_PER_BIT` = `CLOCK_FREQ/BAUD_RATE`, using integer division (10416 at the defaults).
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- uartTX `clk`: input, 1 bit, system clock; all logic on the rising edge.
- uartTX `rst`: input, 1 bit, synchronous, active-high.
- uartTX `data_in`: input, 8 bits, byte to send; sampled only on an accepted `transmit`.
- uartTX `transmit`: input, 1 bit, start request; a single-cycle pulse is sufficient.
- uartTX `tx`: output, 1 bit, serial line; idles high.
- uartTX `tx_busy`: output, 1 bit, high while a frame is in progress.
- uartRX `clk`: input, 1 bit, system clock.
- uartRX `rst`: input, 1 bit, synchronous, active-high.
- uartRX `rx`: input, 1 bit, asynchronous serial line.
- uartRX `data_out`: output, 8 bits, last correctly received byte.
- uartRX `data_ready`: output, 1 bit, one-cycle strobe marking a new byte on `data_out`.

## Operation
- Frame format: start bit 0, then 8 data bits LSB first, then 1 stop bit 1. No parity.
- TX states and transitions:
  - IDLE: `tx`=1, `tx_busy`=0. `transmit`=1 latches `data_in` into a shift register and moves to START.
  - START → DATA(0..7) → STOP → IDLE. Each state lasts exactly `CLKS_PER_BIT` clocks.
  - `transmit` is ignored in every state except IDLE; `data_in` changes during a frame have no effect.
- RX input: `rx` passes through a 2-flop synchronizer. All logic below uses the synchronized signal.
- RX states and transitions:
  - IDLE: a 1→0 transition moves to START.
  - START: wait `CLKS_PER_BIT/2` clocks, then resample. If the line is still 0, go to DATA; otherwise it is a false start and the state returns to IDLE.
  - DATA: sample every `CLKS_PER_BIT` clocks at mid-bit and shift in LSB first, for 8 bits.
  - STOP: sample at mid-bit. A 1 loads the byte into `data_out`, pulses `data_ready` for one cycle and returns to IDLE. A 0 is a framing error: the byte is discarded, there is no strobe, and the receiver waits in IDLE for the line to go high before arming for a new falling edge.
- `data_out` holds its value until the next good frame.
- Reset at any time, including mid-frame, aborts immediately to IDLE with the reset values below.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `data_out`=8'h00, `data_ready`=0; internal counters 0.
- TX: `transmit` sampled high at edge N drives `tx`=0 and `tx_busy`=1 from edge N+1.
- TX frame length is exactly 10×`CLKS_PER_BIT` clocks. `tx_busy` drops on the same edge that ends STOP.
- A new `transmit` is accepted on the first cycle `tx_busy`=0, giving back-to-back frames with no idle gap.
- RX latency from the start-bit falling edge to `data_ready`: 2 clocks (synchronizer) + 9.5×`CLKS_PER_BIT` ± 1 clock.
- RX returns to IDLE at mid-stop-bit, so it is armed for a start bit arriving immediately after the stop bit.
- Counters are wide enough for `CLKS_PER_BIT`−1 ($clog2-sized). The bit index is 3 bits and does not wrap during DATA.

## Structure
- Package `uart_pkg`:
  - `CLKS_PER_BIT` computation as a function of the two parameters.
  - TX state enum: IDLE/START/DATA/STOP.
  - RX state enum: IDLE/START/DATA/STOP.
  - Frame constants: 8 data bits, start level 0, stop level 1.
- Modules `uartTX` and `uartRX` are independent and share only the package.
- Natural sub-module `uart_baud_counter`:
  - loadable down-counter producing a one-cycle `tick`;
  - `load` selects a full-bit count or a half-bit count;
  - used by both TX and RX.

## Test plan
- Loopback TX→RX at defaults, sending 8'hA5, 8'h3C, 8'hFF, 8'h00 with 2 bit periods of idle between them: each produces exactly one `data_ready` with `data_out` equal to the byte sent. Each `tx` frame is 104,160 clocks long.
- Send 8'hA5 and check `tx` bit by bit: 0,1,0,1,0,0,1,0,1,1, each held 10416 clocks. `tx_busy` is high for exactly that span.
- Pulse `transmit` with 8'h3C mid-frame while 8'h A5 is sending: ignored. Only 8'hA5 is received and `tx_busy` does not extend.
- Drive `rx` low for 3000 clocks, then high: false start, so no `data_ready` and `data_out` is unchanged.
- Send a frame with the stop bit forced to 0: no `data_ready`. A following valid frame with 8'h5A is then received correctly.
- Assert `rst` for 1 cycle mid-frame on both modules: `tx`=1, `tx_busy`=0, `data_ready`=0 on the next edge. A subsequent 8'hC3 transfer succeeds.
